// File: rtl/interleaver_pingpong_ctrl_pkg.sv
// Shared constants and FSM state types for the interleaver ping-pong store.
package wimax_intlv_pkg;

    localparam int unsigned NCBPS_QPSK = 192;
    localparam int unsigned INTLV_D    = 16;
    localparam int unsigned INTLV_IDXW = $clog2(NCBPS_QPSK) + 1;

    typedef enum logic {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

endpackage

// File: rtl/interleaver_pingpong_ctrl_if.sv
// Interleaver-side write handshake and modulator-side read handshake.
interface interleaver_pingpong_ctrl_if
    import wimax_intlv_pkg::*;
#(
    parameter int unsigned IDXW = INTLV_IDXW
);
    logic            in_valid;
    logic            in_data;
    logic [IDXW-1:0] in_index;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic            out_data;
    logic            out_last;

    modport master (
        output in_valid, in_data, in_index, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_index, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/interleaver_pingpong_ctrl_bank.sv
// One NCBPS-bit bank with indexed write and read ports.
// Optional written-mask duplicate detection: define INTLV_DUP_CHECK_EN.
module intlv_bank
    import wimax_intlv_pkg::*;
#(
    parameter int unsigned NCBPS = NCBPS_QPSK
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       we,
    input  logic [$clog2(NCBPS)-1:0]   waddr,
    input  logic                       wdata,
    input  logic [$clog2(NCBPS)-1:0]   raddr,
    output logic                       rdata,
    input  logic                       mask_clr,
    output logic                       dup_hit
);
    logic [NCBPS-1:0] mem_q;
    logic [NCBPS-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are don't-care after reset; only the control flags are reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

`ifdef INTLV_DUP_CHECK_EN
    logic [NCBPS-1:0] mask_q;
    logic [NCBPS-1:0] mask_d;

    always_comb begin
        mask_d = mask_q;
        if (we) begin
            mask_d[waddr] = 1'b1;
        end
        if (mask_clr) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign dup_hit = we & mask_q[waddr];
`else
    logic unused_mask_sigs;
    assign unused_mask_sigs = resetN ^ mask_clr;
    assign dup_hit          = 1'b0;
`endif

endmodule

// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong bit store between interleaver and modulator: fill one bank by index, drain the other in order.
// Duplicate-index detection is built only when INTLV_DUP_CHECK_EN is defined (see intlv_bank).
module interleaver_pingpong_ctrl
    import wimax_intlv_pkg::*;
#(
    parameter int unsigned NCBPS = NCBPS_QPSK
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        flush,
    interleaver_pingpong_ctrl_if.slave  bus,
    output logic                        idx_err,
    output logic                        dup_err
);
    localparam int unsigned AW       = $clog2(NCBPS);
    localparam int unsigned IDXW     = $clog2(NCBPS) + 1;
    localparam logic [AW-1:0] CNT_LAST = AW'(NCBPS - 1);

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic        wr_bank_q,  wr_bank_d;
    logic        rd_bank_q,  rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]  bank_full_q, bank_full_d;
    logic        idx_err_q,  idx_err_d;
    logic        dup_err_q,  dup_err_d;

    logic          in_ready_c;
    logic          out_valid_c;
    logic          wr_acc;
    logic          rd_acc;
    logic          wr_done;
    logic          rd_done;
    logic          idx_ok;
    logic [AW-1:0] wr_addr;
    logic [1:0]    bank_we;
    logic [1:0]    bank_clr;
    logic [1:0]    bank_rdata;
    logic [1:0]    bank_dup;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        intlv_bank #(.NCBPS(NCBPS)) u_bank (
            .clk      (clk),
            .resetN   (resetN),
            .we       (bank_we[b]),
            .waddr    (wr_addr),
            .wdata    (bus.in_data),
            .raddr    (rd_cnt_q),
            .rdata    (bank_rdata[b]),
            .mask_clr (bank_clr[b]),
            .dup_hit  (bank_dup[b])
        );
    end

    // Handshakes; flush wins over any same-cycle transfer.
    always_comb begin
        in_ready_c  = (wr_state_q == W_FILL) && !bank_full_q[wr_bank_q];
        out_valid_c = (rd_state_q == R_DRAIN);
        wr_acc      = bus.in_valid && in_ready_c && !flush;
        rd_acc      = out_valid_c && bus.out_ready && !flush;
        idx_ok      = bus.in_index < IDXW'(NCBPS);
        wr_addr     = AW'(bus.in_index);
        wr_done     = wr_acc && (wr_cnt_q == CNT_LAST);
        rd_done     = rd_acc && (rd_cnt_q == CNT_LAST);
    end

    // Bank flags and per-bank write/mask-clear strobes.
    always_comb begin
        bank_full_d = bank_full_q;
        bank_we     = '0;
        bank_clr    = {2{flush}};
        if (wr_acc && idx_ok) begin
            bank_we[wr_bank_q] = 1'b1;
        end
        if (wr_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
            bank_clr[~wr_bank_q]   = 1'b1;
        end
        if (rd_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (flush) begin
            bank_full_d = '0;
        end
    end

    // Writer: block boundary is the write count, never the index value.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        case (wr_state_q)
            W_FILL: begin
                if (wr_acc) begin
                    if (wr_done) begin
                        wr_cnt_d  = '0;
                        wr_bank_d = ~wr_bank_q;
                        if (bank_full_d[~wr_bank_q]) begin
                            wr_state_d = W_WAIT;
                        end
                    end else begin
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            W_WAIT: begin
                if (!bank_full_q[wr_bank_q]) begin
                    wr_state_d = W_FILL;
                end
            end
            default: wr_state_d = W_FILL;
        endcase
        if (flush) begin
            wr_state_d = W_FILL;
            wr_bank_d  = 1'b0;
            wr_cnt_d   = '0;
        end
    end

    // Reader: looks at next-cycle flags so a just-completed bank drains without a bubble.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (bank_full_d[rd_bank_q]) begin
                    rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (rd_acc) begin
                    if (rd_done) begin
                        rd_cnt_d   = '0;
                        rd_bank_d  = ~rd_bank_q;
                        rd_state_d = bank_full_d[~rd_bank_q] ? R_DRAIN : R_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + AW'(1);
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
        if (flush) begin
            rd_state_d = R_IDLE;
            rd_bank_d  = 1'b0;
            rd_cnt_d   = '0;
        end
    end

    // Sticky error flags survive flush; only reset clears them.
    always_comb begin
        idx_err_d = idx_err_q | (wr_acc & ~idx_ok);
        dup_err_d = dup_err_q | (|bank_dup);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_state_q  <= W_FILL;
            rd_state_q  <= R_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            bank_full_q <= '0;
            idx_err_q   <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            bank_full_q <= bank_full_d;
            idx_err_q   <= idx_err_d;
            dup_err_q   <= dup_err_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_valid_c & bank_rdata[rd_bank_q];
    assign bus.out_last  = out_valid_c & (rd_cnt_q == CNT_LAST);
    assign idx_err       = idx_err_q;
    assign dup_err       = dup_err_q;

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Scoreboard bench for interleaver_pingpong_ctrl; dup checks follow INTLV_DUP_CHECK_EN.
module tb_interleaver_pingpong_ctrl;
    import wimax_intlv_pkg::*;

    localparam int unsigned N    = NCBPS_QPSK;
    localparam int unsigned IDXW = $clog2(N) + 1;

    typedef struct packed {
        logic d;
        logic last;
        logic dc;
    } exp_t;

    logic clk    = 1'b0;
    logic resetN = 1'b1;
    logic flush  = 1'b0;
    logic idx_err;
    logic dup_err;

    interleaver_pingpong_ctrl_if #(.IDXW(IDXW)) bus ();

    interleaver_pingpong_ctrl #(.NCBPS(N)) dut (
        .clk     (clk),
        .resetN  (resetN),
        .flush   (flush),
        .bus     (bus),
        .idx_err (idx_err),
        .dup_err (dup_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t_first;
    int   t_last;
    logic pre_valid;
    bit   rand_rdy = 1'b0;
    exp_t sbq[$];
    logic out_log[$];
    int   blk_idx[N];
    bit   blk_dat[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected bit per accepted output beat.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (resetN && bus.out_valid && bus.out_ready) begin
                out_log.push_back(bus.out_data);
                chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    if (!e.dc) chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_last", 32'(bus.out_last), 32'(e.last));
                end
            end else if (!bus.out_valid) begin
                chk("idle_outputs", 32'({bus.out_data, bus.out_last}), 32'd0);
            end
        end
    end

    initial begin : random_ready
        forever begin
            @(negedge clk);
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_bit(input int idx, input logic d);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_index = IDXW'(idx);
        while (!bus.in_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_block(input int n);
        logic e_d[N];
        logic e_w[N];
        exp_t e;
        for (int j = 0; j < N; j++) begin
            e_d[j] = 1'b0;
            e_w[j] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            if (k == N - 1) pre_valid = bus.out_valid;
            send_bit(blk_idx[k], blk_dat[k]);
            if (k == 0) t_first = cyc;
            if (blk_idx[k] < int'(N)) begin
                e_d[blk_idx[k]] = blk_dat[k];
                e_w[blk_idx[k]] = 1'b1;
            end
        end
        t_last = cyc;
        bus.in_valid = 1'b0;
        if (n == N) begin
            for (int j = 0; j < N; j++) begin
                e.d    = e_d[j];
                e.last = (j == N - 1);
                e.dc   = !e_w[j];
                sbq.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sbq.size() != 0 && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_done", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_identity(input bit rnd);
        for (int k = 0; k < N; k++) begin
            blk_idx[k] = k;
            blk_dat[k] = rnd ? ($urandom_range(0, 1) == 1) : (k % 3 == 0);
        end
    endtask

    // First permutation for Ncbps=192, d=16 (s=1 makes the second one identity).
    task automatic fill_perm(input bit rnd);
        for (int k = 0; k < N; k++) begin
            blk_idx[k] = 12 * (k % 16) + k / 16;
            blk_dat[k] = rnd ? ($urandom_range(0, 1) == 1) : (k == 1 || k == 16);
        end
    endtask

    initial begin : stimulus
        int ones;
        bus.in_valid  = 1'b0;
        bus.in_data   = 1'b0;
        bus.in_index  = '0;
        bus.out_ready = 1'b0;

        #2 resetN = 1'b0;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_idx_err",   32'(idx_err),       32'd0);
        chk("rst_dup_err",   32'(dup_err),       32'd0);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b1;

        // Identity block: latency and out_last placement.
        fill_identity(1'b0);
        send_block(N);
        chk("id_valid_before_last", 32'(pre_valid), 32'd0);
        chk("id_valid_after_last",  32'(bus.out_valid), 32'd1);
        chk("id_latency_edges",     32'(t_last - t_first), 32'(N - 1));
        wait_drain();

        // Real permutation: input 1 -> pos 12, input 16 -> pos 1.
        out_log.delete();
        fill_perm(1'b0);
        send_block(N);
        wait_drain();
        chk("perm_count", 32'(out_log.size()), 32'(N));
        if (out_log.size() == N) begin
            chk("perm_pos12", 32'(out_log[12]), 32'd1);
            chk("perm_pos1",  32'(out_log[1]),  32'd1);
            ones = 0;
            foreach (out_log[i]) ones += int'(out_log[i]);
            chk("perm_ones", 32'(ones), 32'd2);
        end

        // Back-pressure: two banks fill, the 385th bit is refused.
        bus.out_ready = 1'b0;
        fill_identity(1'b1);
        send_block(N);
        fill_perm(1'b1);
        send_block(N);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("bp_hold_ready", 32'(bus.in_ready),  32'd0);
        chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        fill_identity(1'b1);
        send_block(N);
        wait_drain();
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);

        // Random out_ready over four continuous blocks.
        rand_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            fill_perm(1'b1);
            send_block(N);
        end
        wait_drain();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

        // Out-of-range index: dropped, counted, sticky flag.
        chk("idx_err_pre", 32'(idx_err), 32'd0);
        fill_identity(1'b0);
        blk_idx[50] = 200;
        send_block(N);
        chk("idx_err_set",     32'(idx_err),       32'd1);
        chk("idx_block_close", 32'(bus.out_valid), 32'd1);
        wait_drain();

        // Duplicate index 5 (position 6 never written).
        chk("dup_err_pre", 32'(dup_err), 32'd0);
        fill_identity(1'b1);
        blk_dat[5] = 1'b0;
        blk_dat[6] = 1'b1;
        blk_idx[6] = 5;
        send_block(N);
`ifdef INTLV_DUP_CHECK_EN
        chk("dup_err_set", 32'(dup_err), 32'd1);
`else
        chk("dup_err_tied", 32'(dup_err), 32'd0);
`endif
        wait_drain();

        // Flush at bit 100, then a clean block must close at exactly 192 writes.
        fill_identity(1'b1);
        send_block(100);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready",  32'(bus.in_ready),  32'd1);
        chk("flush_keeps_idx", 32'(idx_err),       32'd1);
        repeat (2) @(negedge clk);
        fill_perm(1'b1);
        send_block(N);
        chk("flush_latency", 32'(t_last - t_first), 32'(N - 1));
        chk("flush_close",   32'(bus.out_valid),    32'd1);
        wait_drain();

        // Reset pulsed mid-drain.
        fill_identity(1'b1);
        send_block(N);
        repeat (40) @(negedge clk);
        chk("mid_drain_valid", 32'(bus.out_valid), 32'd1);
        resetN = 1'b0;
        #1;
        chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_out_data",  32'(bus.out_data),  32'd0);
        chk("rst2_out_last",  32'(bus.out_last),  32'd0);
        chk("rst2_idx_err",   32'(idx_err),       32'd0);
        chk("rst2_dup_err",   32'(dup_err),       32'd0);
        sbq.delete();
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        fill_perm(1'b1);
        send_block(N);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
